// File: rtl/ysyx_22050518_ifu_if.sv
// Instruction-memory request/response bus between the fetch unit and the I-side memory.
// One outstanding request at a time; the response is a single-cycle rvalid pulse.
interface ysyx_22050518_ifu_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ysyx_22050518_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with a one-entry instruction buffer
// and redirect handling that drops responses belonging to a stale fetch.
//
// state  | meaning
// S_REQ  | PC valid, issuing a request when fetch_en allows
// S_WAIT | request accepted, awaiting imem_rvalid
// S_FULL | instruction buffered, offered to decode
module ysyx_22050518_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [63:0]                redirect_addr,
    input  logic                       fetch_en,
    ysyx_22050518_ifu_if.master        imem,
    output logic                       ivalid,
    output logic [31:0]                inst,
    output logic [63:0]                inst_pc,
    input  logic                       pipe2_allowin,
    output logic [63:0]                fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] inflight_addr;
    logic        drop;

    assign imem.imem_req  = (state == S_REQ) & fetch_en & ~redirect;
    assign imem.imem_addr = pc;
    assign ivalid         = (state == S_FULL) & ~redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            inflight_addr <= 64'd0;
            drop          <= 1'b0;
            inst          <= 32'd0;
            inst_pc       <= 64'd0;
            fetch_cnt     <= 64'd0;
        end else begin
            case (state)
                S_REQ: begin
                    // A stray rvalid here belongs to a request abandoned by reset; ignore it.
                    if (redirect) begin
                        pc <= redirect_addr;
                    end else if (imem.imem_req && imem.imem_ready) begin
                        inflight_addr <= pc;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (drop || redirect) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                            if (redirect) begin
                                pc <= redirect_addr;
                            end
                        end else begin
                            inst    <= imem.imem_rdata;
                            inst_pc <= inflight_addr;
                            pc      <= pc + 64'd4;
                            state   <= S_FULL;
                        end
                    end else if (redirect) begin
                        // Response is still owed by memory; remember to discard it.
                        pc   <= redirect_addr;
                        drop <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (redirect) begin
                        pc    <= redirect_addr;
                        state <= S_REQ;
                    end else if (pipe2_allowin) begin
                        fetch_cnt <= fetch_cnt + 64'd1;
                        state     <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_ifu.sv
// Self-checking bench for the fetch unit: directed fetch/redirect/reset sequences with a
// scoreboard of expected (pc, word) pairs pushed on response and popped on decode accept.
module tb_ysyx_22050518_ifu;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [63:0] redirect_addr;
    logic        fetch_en;
    logic        ivalid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        pipe2_allowin;
    logic [63:0] fetch_cnt;

    ysyx_22050518_ifu_if bus ();

    ysyx_22050518_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_en      (fetch_en),
        .imem          (bus),
        .ivalid        (ivalid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .pipe2_allowin (pipe2_allowin),
        .fetch_cnt     (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_pc;
    logic [63:0] exp_cnt;
    logic [63:0] cur_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // In S_REQ with fetch_en=1 and imem_ready=1: expect the request at exp_pc, accept it.
    task automatic issue();
        #1;
        chk("imem_req", 64'(bus.imem_req), 64'd1);
        chk("imem_addr", bus.imem_addr, exp_pc);
        chk("ivalid_req", 64'(ivalid), 64'd0);
        cur_addr = exp_pc;
        tick();
    endtask

    // In S_WAIT: deliver the response after 'delay' cycles (1 = minimum latency).
    task automatic respond(input int delay);
        for (int i = 1; i < delay; i++) begin
            #1;
            chk("wait_req", 64'(bus.imem_req), 64'd0);
            chk("wait_ivalid", 64'(ivalid), 64'd0);
            tick();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of(cur_addr);
        sb.push_back('{pc: cur_addr, word: word_of(cur_addr)});
        exp_pc = cur_addr + 64'd4;
        #1;
        chk("rvalid_req", 64'(bus.imem_req), 64'd0);
        chk("rvalid_ivalid", 64'(ivalid), 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
    endtask

    // In S_FULL: hold decode back for 'hold' cycles, then accept the buffered instruction.
    task automatic consume(input int hold);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb[0];
        pipe2_allowin = 1'b0;
        for (int i = 0; i < hold; i++) begin
            #1;
            chk("hold_ivalid", 64'(ivalid), 64'd1);
            chk("hold_inst", 64'(inst), 64'(e.word));
            chk("hold_pc", inst_pc, e.pc);
            chk("hold_req", 64'(bus.imem_req), 64'd0);
            chk("hold_cnt", fetch_cnt, exp_cnt);
            tick();
        end
        pipe2_allowin = 1'b1;
        #1;
        e = sb.pop_front();
        chk("ivalid", 64'(ivalid), 64'd1);
        chk("inst", 64'(inst), 64'(e.word));
        chk("inst_pc", inst_pc, e.pc);
        tick();
        pipe2_allowin = 1'b0;
        exp_cnt = exp_cnt + 64'd1;
        chk("fetch_cnt", fetch_cnt, exp_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_addr   = 64'd0;
        fetch_en        = 1'b0;
        pipe2_allowin   = 1'b0;
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        exp_pc          = RESET_PC;
        exp_cnt         = 64'd0;
        cur_addr        = 64'd0;
        repeat (2) tick();
        #1;
        chk("rst_ivalid", 64'(ivalid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_cnt", fetch_cnt, 64'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_req_dis", 64'(bus.imem_req), 64'd0);

        // Sequential fetch at minimum latency.
        rst      = 1'b0;
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue();
            respond(1);
            consume(0);
        end
        chk("cnt3", fetch_cnt, 64'd3);

        // Decode back-pressure for 5 cycles, then slower memory.
        issue(); respond(1); consume(5);
        issue(); respond(3); consume(1);

        // fetch_en low only blocks new issue.
        issue();
        fetch_en = 1'b0;
        respond(2);
        consume(0);
        #1;
        chk("en_off_req", 64'(bus.imem_req), 64'd0);
        tick();
        #1;
        chk("en_off_req2", 64'(bus.imem_req), 64'd0);
        chk("en_off_addr", bus.imem_addr, exp_pc);
        fetch_en = 1'b1;

        // Redirect in S_REQ suppresses that cycle's request.
        redirect = 1'b1; redirect_addr = 64'h8000_0100;
        #1;
        chk("redir_req_req", 64'(bus.imem_req), 64'd0);
        tick();
        redirect = 1'b0;
        exp_pc = 64'h8000_0100;
        issue(); respond(1); consume(0);

        // Redirect in S_WAIT, stale response arrives two cycles later.
        issue();
        redirect = 1'b1; redirect_addr = 64'h8000_1000;
        #1;
        chk("rw_req", 64'(bus.imem_req), 64'd0);
        chk("rw_ivalid0", 64'(ivalid), 64'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rw_ivalid1", 64'(ivalid), 64'd0);
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rw_ivalid2", 64'(ivalid), 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        exp_pc = 64'h8000_1000;
        #1;
        chk("rw_ivalid3", 64'(ivalid), 64'd0);
        issue(); respond(1); consume(0);

        // Redirect coincident with the response.
        issue();
        redirect = 1'b1; redirect_addr = 64'h8000_2000;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAAD_F00D;
        #1;
        chk("rc_ivalid", 64'(ivalid), 64'd0);
        tick();
        redirect = 1'b0; bus.imem_rvalid = 1'b0;
        exp_pc = 64'h8000_2000;
        #1;
        chk("rc_ivalid1", 64'(ivalid), 64'd0);
        issue(); respond(1); consume(0);

        // Redirect in S_FULL squashes the buffered instruction even with allowin.
        issue(); respond(1);
        redirect = 1'b1; redirect_addr = 64'h8000_3000; pipe2_allowin = 1'b1;
        #1;
        chk("rf_ivalid", 64'(ivalid), 64'd0);
        tick();
        redirect = 1'b0; pipe2_allowin = 1'b0;
        void'(sb.pop_front());
        exp_pc = 64'h8000_3000;
        chk("rf_cnt", fetch_cnt, exp_cnt);
        issue(); respond(1); consume(0);

        // PC wraps modulo 2^64.
        redirect = 1'b1; redirect_addr = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        issue(); respond(1); consume(0);
        chk("wrap_pc", exp_pc, 64'd0);
        issue(); respond(1); consume(0);

        // Reset mid-transaction; the late response must be ignored.
        issue();
        rst = 1'b1;
        tick();
        rst = 1'b0; fetch_en = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hCAFE_0001;
        #1;
        chk("late_ivalid0", 64'(ivalid), 64'd0);
        chk("late_cnt0", fetch_cnt, 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        #1;
        chk("late_ivalid1", 64'(ivalid), 64'd0);
        chk("late_addr", bus.imem_addr, RESET_PC);
        chk("late_inst_pc", inst_pc, 64'd0);
        fetch_en = 1'b1;
        exp_pc = RESET_PC;
        exp_cnt = 64'd0;
        issue(); respond(1); consume(0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
